scalar_mult_ctrl: RTL and testbench
===================================

// Module: scalar_mult_ctrl
// PURPOSE
//  Sequences right-to-left (LSB-first) double-and-add scalar multiplication R = k*P.
//  Pulls one key bit per iteration from key_shift via its request/done handshake.
//  Issues start pulses to the shared point-add and point-double units and waits for their done pulses.
//  Sits between the top-level ECC control and the point arithmetic datapath; owns no point registers.
// PARAMETERS
//  KEY_W   32  scalar width in bits = number of iterations
//  CNT_W   6   width of bit counter, >= $clog2(KEY_W+1)
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst_n        in   1      asynchronous active-low reset
//  i_start        in   1      start request, sampled only in IDLE
//  i_k_bit        in   1      current key bit from key_shift (k_out)
//  o_shift_req    out  1      1-cycle pulse: consume current bit, advance key_shift
//  i_shift_done   in   1      1-cycle pulse from key_shift: advance complete
//  o_acc_load     out  1      1-cycle pulse: copy Q into R (R is at infinity)
//  o_add_start    out  1      1-cycle pulse: R <= R + Q
//  i_add_done     in   1      1-cycle pulse: add complete
//  o_dbl_start    out  1      1-cycle pulse: Q <= 2Q
//  i_dbl_done     in   1      1-cycle pulse: double complete
//  o_busy         out  1      high from leaving IDLE until DONE exits
//  o_done         out  1      1-cycle pulse: R valid
//  o_r_inf        out  1      high while R is point at infinity (k==0 at end)
//  o_bit_idx      out  CNT_W  index of bit being processed, 0..KEY_W-1
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE; all pulses 0; o_busy=0; o_r_inf=1; o_bit_idx=0; k_r=0.
//  All outputs registered; pulses last exactly one cycle.
//  States: IDLE, FETCH, WSHIFT, ADD, WADD, DBL, WDBL, DONE.
//  IDLE: i_start=1 -> FETCH; o_r_inf<=1, o_bit_idx<=0, o_busy<=1 next cycle.
//  FETCH (1 cycle): k_r<=i_k_bit; o_shift_req=1 next cycle; -> WSHIFT.
//  WSHIFT: wait for i_shift_done; then k_r=1 -> ADD, k_r=0 -> DBL (last bit: -> DONE).
//  ADD: if o_r_inf=1, pulse o_acc_load, clear o_r_inf, go straight to DBL/DONE (no wait);
//       else pulse o_add_start -> WADD.
//  WADD: wait for i_add_done -> DBL, or -> DONE if o_bit_idx==KEY_W-1.
//  DBL: pulse o_dbl_start -> WDBL. Final double skipped (never issued for bit KEY_W-1).
//  WDBL: i_dbl_done -> o_bit_idx+1, -> FETCH.
//  DONE (1 cycle): o_done=1, o_busy=0 next cycle; -> IDLE.
//  Done/ack pulses arriving outside their wait state are ignored (no latching).
//  i_start while busy ignored; new start accepted in IDLE the cycle after DONE.
//  Add and double never overlap: at most one outstanding unit operation.
//  o_bit_idx never exceeds KEY_W-1; no wrap.
//  Async reset mid-operation aborts immediately; no o_done issued; key_shift reset separately.
//  Iteration cost: 2 (fetch) + shift latency + [add] + double; total pulses: KEY_W shift_req,
//   KEY_W-1 dbl_start, popcount(k)-1 add_start + 1 acc_load (if k!=0).
// TESTING
//  k=0x00000005, shift/add/dbl done latency 3: -> 32 shift_req, 1 acc_load, 1 add_start,
//   31 dbl_start, one o_done, o_r_inf=0.
//  k=0: -> 32 shift_req, 0 add/load, 31 dbl_start, o_done with o_r_inf=1.
//  k=0x80000000: acc_load only on bit 31, no dbl_start after it; o_done next cycles.
//  k=0xFFFFFFFF: 1 acc_load, 31 add_start; each add_start precedes dbl_start of same bit.
//  Spurious i_add_done/i_dbl_done/i_start pulses during WSHIFT -> ignored, counts unchanged.
//  Assert i_rst_n=0 during WADD at bit 10 -> all outputs at reset values immediately;
//   fresh i_start then runs a full 32-bit sequence normally.

Source files
------------

// File: rtl/scalar_mult_ctrl.sv
// Sequencer for LSB-first double-and-add scalar multiplication R = k*P.
// Drives the key shifter and the shared point add/double units through pulse handshakes.
module scalar_mult_ctrl #(
  parameter int KEY_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_k_bit,
  output logic             o_shift_req,
  input  logic             i_shift_done,
  output logic             o_acc_load,
  output logic             o_add_start,
  input  logic             i_add_done,
  output logic             o_dbl_start,
  input  logic             i_dbl_done,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_r_inf,
  output logic [CNT_W-1:0] o_bit_idx
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WSHIFT,
    ADD,
    WADD,
    DBL,
    WDBL,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

  state_t state;
  logic   k_r;
  logic   last_bit;

  assign last_bit = (o_bit_idx == LAST_IDX);

  // The doubling of Q after the final bit would be wasted work, so the last
  // iteration exits to DONE instead of DBL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      k_r         <= 1'b0;
      o_shift_req <= 1'b0;
      o_acc_load  <= 1'b0;
      o_add_start <= 1'b0;
      o_dbl_start <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_r_inf     <= 1'b1;
      o_bit_idx   <= '0;
    end else begin
      o_shift_req <= 1'b0;
      o_acc_load  <= 1'b0;
      o_add_start <= 1'b0;
      o_dbl_start <= 1'b0;
      o_done      <= 1'b0;

      case (state)
        IDLE: begin
          if (i_start) begin
            o_r_inf   <= 1'b1;
            o_bit_idx <= '0;
            o_busy    <= 1'b1;
            state     <= FETCH;
          end
        end

        FETCH: begin
          k_r         <= i_k_bit;
          o_shift_req <= 1'b1;
          state       <= WSHIFT;
        end

        WSHIFT: begin
          if (i_shift_done) begin
            if (k_r) begin
              state <= ADD;
            end else if (last_bit) begin
              state <= DONE;
            end else begin
              state <= DBL;
            end
          end
        end

        // While R is still at infinity the first set bit is a plain copy of Q,
        // which needs no arithmetic unit and therefore no wait state.
        ADD: begin
          if (o_r_inf) begin
            o_acc_load <= 1'b1;
            o_r_inf    <= 1'b0;
            state      <= last_bit ? DONE : DBL;
          end else begin
            o_add_start <= 1'b1;
            state       <= WADD;
          end
        end

        WADD: begin
          if (i_add_done) begin
            state <= last_bit ? DONE : DBL;
          end
        end

        DBL: begin
          o_dbl_start <= 1'b1;
          state       <= WDBL;
        end

        WDBL: begin
          if (i_dbl_done) begin
            if (!last_bit) begin
              o_bit_idx <= o_bit_idx + CNT_W'(1);
            end
            state <= FETCH;
          end
        end

        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl: behavioural key shifter and add/double units with
// fixed latency, an event log of DUT pulses, and a scoreboard of expected pulse totals.
module tb_scalar_mult_ctrl;

  localparam int KEY_W   = 32;
  localparam int CNT_W   = 6;
  localparam int LAT     = 3;
  localparam int TIMEOUT = 5000;

  typedef enum int {EV_SHIFT, EV_LOAD, EV_ADD, EV_DBL, EV_DONE} ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       cyc;
  } ev_t;

  typedef struct {
    int   shifts;
    int   loads;
    int   adds;
    int   dbls;
    logic r_inf;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_start = 1'b0;
  logic             i_k_bit;
  logic             o_shift_req;
  logic             i_shift_done = 1'b0;
  logic             o_acc_load;
  logic             o_add_start;
  logic             i_add_done = 1'b0;
  logic             o_dbl_start;
  logic             i_dbl_done = 1'b0;
  logic             o_busy;
  logic             o_done;
  logic             o_r_inf;
  logic [CNT_W-1:0] o_bit_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  int               start_req   = 0;
  int               start_ack   = 0;
  logic [KEY_W-1:0] key_load    = '0;
  logic [KEY_W-1:0] key_reg     = '0;
  logic             spurious_en = 1'b0;
  int               sh_cnt      = 0;
  int               add_cnt     = 0;
  int               dbl_cnt     = 0;
  int               cyc         = 0;

  ev_t  events[$];
  exp_t sb[$];

  scalar_mult_ctrl #(
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_k_bit     (i_k_bit),
    .o_shift_req (o_shift_req),
    .i_shift_done(i_shift_done),
    .o_acc_load  (o_acc_load),
    .o_add_start (o_add_start),
    .i_add_done  (i_add_done),
    .o_dbl_start (o_dbl_start),
    .i_dbl_done  (i_dbl_done),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_r_inf     (o_r_inf),
    .o_bit_idx   (o_bit_idx)
  );

  always #5 i_clk = ~i_clk;

  assign i_k_bit = key_reg[0];

  // Behavioural key shifter and arithmetic units; each answers its request after LAT cycles.
  always @(negedge i_clk) begin
    i_start      = 1'b0;
    i_shift_done = 1'b0;
    i_add_done   = 1'b0;
    i_dbl_done   = 1'b0;
    if (!i_rst_n) begin
      sh_cnt  = 0;
      add_cnt = 0;
      dbl_cnt = 0;
    end else begin
      if (start_ack != start_req) begin
        start_ack = start_req;
        key_reg   = key_load;
        i_start   = 1'b1;
      end
      if (sh_cnt != 0) begin
        sh_cnt--;
        if (sh_cnt == 0) begin
          i_shift_done = 1'b1;
          key_reg      = key_reg >> 1;
        end else if (spurious_en && sh_cnt == LAT - 1) begin
          i_add_done = 1'b1;
          i_dbl_done = 1'b1;
          i_start    = 1'b1;
        end
      end
      if (add_cnt != 0) begin
        add_cnt--;
        if (add_cnt == 0) i_add_done = 1'b1;
      end
      if (dbl_cnt != 0) begin
        dbl_cnt--;
        if (dbl_cnt == 0) i_dbl_done = 1'b1;
      end
      if (o_shift_req) sh_cnt = LAT;
      if (o_add_start) add_cnt = LAT;
      if (o_dbl_start) dbl_cnt = LAT;
    end
  end

  always @(negedge i_clk) begin
    cyc++;
    if (o_shift_req) events.push_back('{EV_SHIFT, int'(o_bit_idx), cyc});
    if (o_acc_load)  events.push_back('{EV_LOAD,  int'(o_bit_idx), cyc});
    if (o_add_start) events.push_back('{EV_ADD,   int'(o_bit_idx), cyc});
    if (o_dbl_start) events.push_back('{EV_DBL,   int'(o_bit_idx), cyc});
    if (o_done)      events.push_back('{EV_DONE,  int'(o_bit_idx), cyc});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},      o_busy,      1'b0);
    checkOutput({tag, "_done"},      o_done,      1'b0);
    checkOutput({tag, "_r_inf"},     o_r_inf,     1'b1);
    checkOutput({tag, "_bit_idx"},   o_bit_idx,   '0);
    checkOutput({tag, "_shift_req"}, o_shift_req, 1'b0);
    checkOutput({tag, "_acc_load"},  o_acc_load,  1'b0);
    checkOutput({tag, "_add_start"}, o_add_start, 1'b0);
    checkOutput({tag, "_dbl_start"}, o_dbl_start, 1'b0);
  endtask

  // Runs one multiplication and checks every logged pulse against the key it was issued for.
  task automatic applyStimulus(input logic [KEY_W-1:0] k, input logic spur, input string tag);
    exp_t             e;
    ev_t              ev;
    int               base;
    int               waited;
    int               n_sh, n_ld, n_add, n_dbl, n_done;
    int               ld_cyc, done_cyc;
    ev_kind_t         prev_kind;
    int               prev_idx;
    ev_kind_t         want_prev;
    logic [KEY_W-1:0] low_mask;
    logic [KEY_W-1:0] high_mask;

    e.shifts = KEY_W;
    e.loads  = (k != '0) ? 1 : 0;
    e.adds   = (k != '0) ? $countones(k) - 1 : 0;
    e.dbls   = KEY_W - 1;
    e.r_inf  = (k == '0);
    sb.push_back(e);

    key_load    = k;
    spurious_en = spur;
    base        = events.size();
    start_req++;

    waited = 0;
    while (!o_done && waited < TIMEOUT) begin
      @(negedge i_clk);
      waited++;
    end
    #1;
    checkOutput({tag, "_done_seen"}, o_done, 1'b1);

    e = sb.pop_front();
    checkOutput({tag, "_busy_at_done"}, o_busy, 1'b0);
    checkOutput({tag, "_r_inf"}, o_r_inf, e.r_inf);

    n_sh = 0; n_ld = 0; n_add = 0; n_dbl = 0; n_done = 0;
    ld_cyc = -100; done_cyc = 0;
    prev_kind = EV_DONE; prev_idx = -1;
    for (int i = base; i < events.size(); i++) begin
      ev        = events[i];
      low_mask  = (KEY_W'(1) << ev.idx) - KEY_W'(1);
      case (ev.kind)
        EV_SHIFT: begin
          checkOutput({tag, "_shift_idx"}, ev.idx, n_sh);
          n_sh++;
        end
        EV_LOAD: begin
          checkOutput({tag, "_load_bit"}, k[ev.idx], 1'b1);
          checkOutput({tag, "_load_first"}, (k & low_mask) == '0, 1'b1);
          ld_cyc = ev.cyc;
          n_ld++;
        end
        EV_ADD: begin
          checkOutput({tag, "_add_bit"}, k[ev.idx], 1'b1);
          checkOutput({tag, "_add_not_first"}, (k & low_mask) != '0, 1'b1);
          n_add++;
        end
        EV_DBL: begin
          checkOutput({tag, "_dbl_not_last"}, ev.idx < KEY_W - 1, 1'b1);
          if (!k[ev.idx])                 want_prev = EV_SHIFT;
          else if ((k & low_mask) == '0)  want_prev = EV_LOAD;
          else                            want_prev = EV_ADD;
          checkOutput({tag, "_dbl_prev_kind"}, prev_kind, want_prev);
          checkOutput({tag, "_dbl_prev_idx"}, prev_idx, ev.idx);
          n_dbl++;
        end
        default: begin
          done_cyc = ev.cyc;
          n_done++;
        end
      endcase
      prev_kind = ev.kind;
      prev_idx  = ev.idx;
    end

    checkOutput({tag, "_n_shift"}, n_sh, e.shifts);
    checkOutput({tag, "_n_load"},  n_ld, e.loads);
    checkOutput({tag, "_n_add"},   n_add, e.adds);
    checkOutput({tag, "_n_dbl"},   n_dbl, e.dbls);
    checkOutput({tag, "_n_done"},  n_done, 1);

    // A top bit that is also the first set bit ends with a load and then DONE directly.
    high_mask = {1'b0, {(KEY_W-1){1'b1}}};
    if (k[KEY_W-1] && (k & high_mask) == '0) begin
      checkOutput({tag, "_load_to_done"}, done_cyc - ld_cyc, 1);
    end

    @(negedge i_clk);
    checkOutput({tag, "_done_width"}, o_done, 1'b0);
  endtask

  initial begin
    int base;
    int waited;
    int n_done;

    #2 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checkResetOutputs("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    checkResetOutputs("idle");

    applyStimulus(32'h0000_0005, 1'b0, "k5");
    applyStimulus(32'h0000_0000, 1'b0, "k0");
    applyStimulus(32'h8000_0000, 1'b0, "ktop");
    applyStimulus(32'hFFFF_FFFF, 1'b0, "kones");
    applyStimulus(32'h0000_A5C3, 1'b1, "kspur");
    applyStimulus(32'h0000_0001, 1'b1, "kone_spur");
    applyStimulus(KEY_W'($urandom), 1'b0, "krand");

    // Abort a run with reset while the add for bit 10 is outstanding.
    key_load    = '1;
    spurious_en = 1'b0;
    base        = events.size();
    start_req++;
    waited = 0;
    while (!(o_add_start && o_bit_idx == CNT_W'(10)) && waited < TIMEOUT) begin
      @(negedge i_clk);
      waited++;
    end
    checkOutput("abort_add_bit10_seen", o_add_start, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    repeat (3) @(negedge i_clk);
    #1;
    n_done = 0;
    for (int i = base; i < events.size(); i++) begin
      if (events[i].kind == EV_DONE) n_done++;
    end
    checkOutput("abort_no_done", n_done, 0);
    checkResetOutputs("abort_hold");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    applyStimulus(32'hFFFF_FFFF, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
